// File: rtl/rf_mp_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mp_sb_if
//  Description : Bus bundle for the multi-read-port register file with
//                pending-write scoreboard. The master drives write, read
//                address, reservation and clear requests; the slave returns
//                registered read data, pending flags and the sweep busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_mp_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    logic                       we;
    logic [ADDR_W-1:0]          w_addr;
    logic [DATA_W-1:0]          wdata;
    logic [NUM_RD*ADDR_W-1:0]   r_addr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic [NUM_RD-1:0]          r_pend;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_addr;
    logic                       clr_req;
    logic                       clr_busy;

    // Decode/writeback side
    modport master (
        output we, w_addr, wdata, r_addr, rsv_en, rsv_addr, clr_req,
        input  rdata, r_pend, clr_busy
    );

    // Register file side
    modport slave (
        input  we, w_addr, wdata, r_addr, rsv_en, rsv_addr, clr_req,
        output rdata, r_pend, clr_busy
    );
endinterface
`default_nettype wire

// File: rtl/rf_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mp_sb
//  Description : Parametrised NUM_RD-read / 1-write register file with a
//                per-register pending-write scoreboard and a hardware clear
//                sweeper. Register 0 reads as zero and is never written.
//                Optional same-cycle write-to-read forwarding (BYPASS).
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_mp_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    rf_mp_sb_if.slave     bus
);

    localparam int                c_depth     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_first_ptr = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_last_ptr  = ADDR_W'(c_depth - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDR_W-1:0]          r_ptr;

    // Entry 0 is never written; every read of address 0 is forced to zero.
    logic [DATA_W-1:0]          r_mem [c_depth];
    logic [c_depth-1:0]         r_pend_vec;

    logic [NUM_RD*DATA_W-1:0]   r_rdata;
    logic [NUM_RD-1:0]          r_rpend;
    logic [NUM_RD*DATA_W-1:0]   w_rdata_nxt;
    logic [NUM_RD-1:0]          w_rpend_nxt;

    logic [ADDR_W-1:0]          w_ra [NUM_RD];

    logic                       w_idle;
    logic                       w_wr_en;
    logic                       w_rsv_en;
    logic                       w_clr_start;

    // Writes, reservations and clear requests only act while idle;
    // address 0 is dropped on both the write and reserve paths.
    assign w_idle      = (r_state == S_IDLE);
    assign w_wr_en     = w_idle && bus.we     && (bus.w_addr   != '0);
    assign w_rsv_en    = w_idle && bus.rsv_en && (bus.rsv_addr != '0);
    assign w_clr_start = w_idle && bus.clr_req;

    // Split the flat read-address bus into one address per port
    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_rd_addr
            assign w_ra[g] = bus.r_addr[g*ADDR_W +: ADDR_W];
        end
    endgenerate

    // State register; reset parks the FSM in the sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: sweep ends after writing the last entry, clear_req restarts it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_ptr == c_last_ptr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Sweep pointer: starts at 1 (entry 0 needs no clearing), stops at DEPTH-1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= c_first_ptr;
        end else if (r_state == S_CLEAR) begin
            if (r_ptr != c_last_ptr) begin
                r_ptr <= r_ptr + c_first_ptr;
            end
        end else if (w_clr_start) begin
            r_ptr <= c_first_ptr;
        end
    end

    // Storage array: zeroed one entry per cycle by the sweep, else written back
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_ptr] <= '0;
            end else if (w_wr_en) begin
                r_mem[bus.w_addr] <= bus.wdata;
            end
        end
    end

    // Scoreboard: writeback clears, issue sets; a same-cycle set wins because
    // it belongs to a younger instruction. A clear request wipes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_vec <= '0;
        end else if (w_clr_start) begin
            r_pend_vec <= '0;
        end else begin
            if (w_wr_en) begin
                r_pend_vec[bus.w_addr] <= 1'b0;
            end
            if (w_rsv_en) begin
                r_pend_vec[bus.rsv_addr] <= 1'b1;
            end
        end
    end

    // Per-port read mux: zero register, optional forwarding, then stored state
    always_comb begin
        w_rdata_nxt = '0;
        w_rpend_nxt = '0;
        if (w_idle) begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (w_ra[i] == '0) begin
                    w_rdata_nxt[i*DATA_W +: DATA_W] = '0;
                    w_rpend_nxt[i]                  = 1'b0;
                end else if ((BYPASS != 0) && w_wr_en && (bus.w_addr == w_ra[i])) begin
                    w_rdata_nxt[i*DATA_W +: DATA_W] = bus.wdata;
                    w_rpend_nxt[i]                  = 1'b0;
                end else begin
                    w_rdata_nxt[i*DATA_W +: DATA_W] = r_mem[w_ra[i]];
                    w_rpend_nxt[i]                  = r_pend_vec[w_ra[i]];
                end
            end
        end
    end

    // Registered read outputs (forced to zero while sweeping via the mux)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_rpend <= '0;
        end else begin
            r_rdata <= w_rdata_nxt;
            r_rpend <= w_rpend_nxt;
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.r_pend   = r_rpend;
    assign bus.clr_busy = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_rf_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_mp_sb
//  Description : Scoreboard bench for rf_mp_sb. Stimulus pushes the expected
//                response of a behavioural model; a monitor pops and compares
//                one entry after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_mp_sb;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NUM_RD = 2;
    localparam int BYPASS = 1;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [NUM_RD*DATA_W-1:0] rd;
        logic [NUM_RD-1:0]        rp;
        logic                     busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    exp_t q[$];
    exp_t mon_e;

    // Reference model state
    logic [DATA_W-1:0] m_mem  [DEPTH];
    bit                m_pend [DEPTH];
    int                m_busy;

    rf_mp_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    rf_mp_sb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM_RD*ADDR_W-1:0] pk(input logic [ADDR_W-1:0] a0,
                                                    input logic [ADDR_W-1:0] a1);
        return {a1, a0};
    endfunction

    // Drive one cycle of inputs and push the model's response for that edge
    task automatic step(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd, input logic [NUM_RD*ADDR_W-1:0] ra,
                        input logic rsv, input logic [ADDR_W-1:0] rsa, input logic clr);
        exp_t e;
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        rst_n        = rst;
        bus.we       = we;
        bus.w_addr   = wa;
        bus.wdata    = wd;
        bus.r_addr   = ra;
        bus.rsv_en   = rsv;
        bus.rsv_addr = rsa;
        bus.clr_req  = clr;
        e.rd = '0;
        e.rp = '0;
        if (!rst) begin
            m_busy = DEPTH - 1;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 0;
            end
        end else if (m_busy > 0) begin
            m_busy--;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                a = ra[p*ADDR_W +: ADDR_W];
                if (a != 0) begin
                    if (BYPASS != 0 && we && wa == a) begin
                        e.rd[p*DATA_W +: DATA_W] = wd;
                    end else begin
                        e.rd[p*DATA_W +: DATA_W] = m_mem[a];
                        e.rp[p]                  = m_pend[a];
                    end
                end
            end
            if (we && wa != 0) begin
                m_mem[wa]  = wd;
                m_pend[wa] = 0;
            end
            if (rsv && rsa != 0) m_pend[rsa] = 1;
            if (clr) begin
                m_busy = DEPTH - 1;
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i]  = '0;
                    m_pend[i] = 0;
                end
            end
        end
        e.busy = (m_busy > 0);
        q.push_back(e);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        step(1, 0, '0, '0, pk(a0, a1), 0, '0, 0);
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            mon_e  = q.pop_front();
            checks = checks + 3;
            if (bus.rdata !== mon_e.rd) begin
                errors++;
                $display("FAIL rdata t=%0t got=%h exp=%h", $time, bus.rdata, mon_e.rd);
            end
            if (bus.r_pend !== mon_e.rp) begin
                errors++;
                $display("FAIL r_pend t=%0t got=%b exp=%b", $time, bus.r_pend, mon_e.rp);
            end
            if (bus.clr_busy !== mon_e.busy) begin
                errors++;
                $display("FAIL clr_busy t=%0t got=%b exp=%b", $time, bus.clr_busy, mon_e.busy);
            end
        end
    end

    logic [ADDR_W-1:0] ra0, ra1, wa, rsa;

    initial begin
        checks       = 0;
        errors       = 0;
        m_busy       = DEPTH - 1;
        rst_n        = 1'b0;
        bus.we       = 1'b0;
        bus.w_addr   = '0;
        bus.wdata    = '0;
        bus.r_addr   = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
        bus.clr_req  = 1'b0;

        // Power-up reset and first sweep
        repeat (2) step(0, 0, '0, '0, '0, 0, '0, 0);
        repeat (16) rd(4'd1, 4'd2);

        // Load garbage, then reset and sweep again
        for (int i = 1; i < DEPTH; i++)
            step(1, 1, ADDR_W'(i), DATA_W'($urandom), pk(ADDR_W'(i), '0), 1, ADDR_W'(DEPTH - i), 0);
        repeat (2) step(0, 1, 4'd3, 16'hDEAD, pk(4'd3, 4'd4), 1, 4'd3, 0);
        repeat (15) step(1, 1, 4'd6, 16'h6666, pk(4'd6, 4'd6), 1, 4'd6, 0);
        for (int i = 1; i < DEPTH; i++) rd(ADDR_W'(i), ADDR_W'(DEPTH - i));

        // Write with same-cycle read (forwarded), then re-read
        step(1, 1, 4'd5, 16'hBEEF, pk(4'd5, 4'd0), 0, '0, 0);
        rd(4'd5, 4'd5);

        // Register 0: write and reserve are dropped
        step(1, 1, 4'd0, 16'h1234, pk(4'd0, 4'd0), 1, 4'd0, 0);
        rd(4'd0, 4'd0);

        // Scoreboard on address 3
        step(1, 0, '0, '0, pk(4'd0, 4'd3), 1, 4'd3, 0);
        rd(4'd0, 4'd3);
        step(1, 1, 4'd3, 16'h00AA, pk(4'd0, 4'd3), 0, '0, 0);
        rd(4'd3, 4'd3);

        // Write and reserve the same address together
        step(1, 1, 4'd7, 16'h5555, pk(4'd7, 4'd0), 1, 4'd7, 0);
        rd(4'd7, 4'd7);

        // Fill with 0xFFFF, some pending, then clear sweep with ignored traffic
        for (int i = 1; i < DEPTH; i++)
            step(1, 1, ADDR_W'(i), 16'hFFFF, '0, 1, ADDR_W'((i + 1) % DEPTH), 0);
        rd(4'd2, 4'd9);
        step(1, 0, '0, '0, pk(4'd1, 4'd2), 0, '0, 1);
        for (int i = 0; i < 15; i++)
            step(1, 1, ADDR_W'(i + 1), 16'hA5A5, pk(ADDR_W'(i + 1), 4'd5), 1, ADDR_W'(i + 1), 1);
        for (int i = 1; i < DEPTH; i++) rd(ADDR_W'(i), ADDR_W'(i));

        // Reset in the middle of a sweep restarts it
        step(1, 1, 4'd9, 16'h9999, '0, 1, 4'd9, 0);
        step(1, 0, '0, '0, '0, 0, '0, 1);
        repeat (6) rd(4'd9, 4'd9);
        step(0, 0, '0, '0, '0, 0, '0, 0);
        repeat (16) rd(4'd9, 4'd1);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            wa  = ADDR_W'($urandom);
            rsa = ADDR_W'($urandom);
            ra0 = ($urandom_range(0, 3) == 0) ? wa  : ADDR_W'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? rsa : ADDR_W'($urandom);
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 1) == 1), wa, DATA_W'($urandom), pk(ra0, ra1),
                 ($urandom_range(0, 4) < 2), rsa,
                 ($urandom_range(0, 99) == 0));
        end

        // Drain and confirm every expected response was consumed
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_mp_sb.md
Name: rf_mp_sb

Overview:
- Parametrised multi-read-port, single-write-port register file with a per-register pending-write scoreboard and a hardware clear sweeper.
- Successor to the fixed 16x16 dual-port RF memory. Read port count, data width and depth are parameters; same-cycle write-to-read bypass is selectable.
- Sits in the CPU decode stage. Read ports feed operand latches; the write port is driven by writeback; the scoreboard is set at issue and cleared at writeback.
- Register 0 is hardwired to zero.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (>=1)
BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to rdata; 0 = the read returns the old contents

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset
we  input  1  write enable
w_addr  input  ADDR_W  write address
wdata  input  DATA_W  write data
r_addr  input  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  registered read data; port i = bits [i*DATA_W +: DATA_W]
r_pend  output  NUM_RD  registered pending flag for each port's read address
rsv_en  input  1  reserve (mark pending) request
rsv_addr  input  ADDR_W  register to reserve
clr_req  input  1  request a full clear sweep (honoured in IDLE only)
clr_busy  output  1  high while the clear sweep runs

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-low (rst_n sampled on posedge clk). No negedge logic.
- Reset values while rst_n=0:
  - rdata=0, r_pend=0, clr_busy=1.
  - All pend bits = 0.
  - FSM=CLEAR, sweep pointer ptr=1.
  - Memory contents are cleared by the sweep, not by reset itself.
- FSM:
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr. The cycle with ptr==DEPTH-1 writes and moves to IDLE. clr_busy=1 throughout CLEAR, so it stays high for exactly DEPTH-1 cycles after rst_n rises (15 for defaults), then drops to 0.
  - IDLE: clr_req=1 sets ptr=1, clears all pend bits and enters CLEAR on the next edge. clr_req is ignored while in CLEAR.
  - Reset asserted mid-sweep restarts the sweep from ptr=1.
- During CLEAR:
  - we and rsv_en are ignored; no write or reservation takes effect.
  - Every port registers rdata=0 and r_pend=0.
- Write: in IDLE, if we=1 and w_addr!=0, mem[w_addr]<=wdata and pend[w_addr]<=0. A write to address 0 is dropped entirely.
- Read, per port i, 1-cycle latency. At the edge after r_addr_i is presented:
  - if r_addr_i==0: rdata_i=0 and r_pend_i=0.
  - else if BYPASS=1 and we=1 and w_addr==r_addr_i: rdata_i=wdata and r_pend_i=0.
  - else: rdata_i=mem[r_addr_i] and r_pend_i=pend[r_addr_i], both pre-edge values.
  - Any number of ports may read the same address in the same cycle.
- Reservation: in IDLE, if rsv_en=1 and rsv_addr!=0, pend[rsv_addr]<=1.
  - A reservation in cycle k is not visible to reads issued in cycle k; it is visible from cycle k+1 reads.
  - rsv_addr=0 is ignored.
- Simultaneous write and reserve to the same address:
  - the write data lands;
  - pend ends at 1 (set wins, because the new reservation belongs to a younger instruction);
  - a same-cycle bypassed read reports r_pend=0.
- A write to an address that is not pending is legal; pend stays 0.
- Widths: no arithmetic beyond ptr, which is ADDR_W bits and never wraps past DEPTH-1 inside CLEAR.
- Storage: flop array DEPTH x DATA_W plus a DEPTH-bit pend vector. Entry 0 storage may be omitted.

Test Plan:
- Reset and sweep, defaults. Pre-load garbage, hold rst_n=0 for 2 cycles, then release. Required: clr_busy=1 for exactly 15 cycles then 0; reading addresses 1..15 afterwards returns 0x0000 with r_pend=0.
- Write/read and bypass. we=1, w_addr=5, wdata=0xBEEF with r_addr port0=5 in the same cycle. Required: BYPASS=1 gives rdata0=0xBEEF next cycle; BYPASS=0 gives 0x0000, then 0xBEEF on a re-read one cycle later.
- Register 0. Write 0x1234 to address 0 and reserve address 0, then read address 0 on all ports. Required: rdata=0, r_pend=0.
- Scoreboard.
  - Reserve address 3 in cycle k while port1 reads 3 in cycle k. Required: r_pend1=0.
  - Read 3 at k+1. Required: r_pend1=1.
  - Write 3 with 0x00AA at k+2 while reading 3. Required: bypassed rdata1=0x00AA, r_pend1=0; a later read shows pend 0.
- Write and reserve address 7 in the same cycle with 0x5555. Required: mem[7]=0x5555 and a subsequent read shows r_pend=1.
- clr_req after writing 0xFFFF to addresses 1..15 with some pending.
  - Required: 15 busy cycles; we/rsv_en ignored during the sweep; all registers read 0 with pend 0 afterwards.
  - Reassert rst_n=0 at sweep cycle 6. Required: the sweep restarts and busy lasts 15 cycles from release.
